// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port synchronous instruction memory between
// the fetch path (read-only) and the loader/debug port (read/write).
// One access per cycle, round-robin on contention, loader burst lock with a
// bounded fetch starvation window, and one-cycle-late read data steering.
module imem_arbiter #(
    parameter int ADDR     = 16,
    parameter int WORD     = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            f_req,
    input  logic [ADDR-1:0] f_addr,
    output logic            f_gnt,
    output logic            f_rvalid,
    output logic [WORD-1:0] f_rdata,

    input  logic            l_req,
    input  logic            l_we,
    input  logic [ADDR-1:0] l_addr,
    input  logic [WORD-1:0] l_wdata,
    input  logic            l_lock,
    output logic            l_gnt,
    output logic            l_rvalid,
    output logic [WORD-1:0] l_rdata,

    output logic [ADDR-1:0] mem_A,
    output logic            mem_W,
    output logic [WORD-1:0] mem_D,
    input  logic [WORD-1:0] mem_Q
);

    typedef enum logic {
        OWN_FETCH  = 1'b0,
        OWN_LOADER = 1'b1
    } owner_t;

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    owner_t     r_last_owner;
    owner_t     r_rd_owner;
    logic       r_rd_pending;
    logic [7:0] r_wait_cnt;

    logic       w_f_gnt;
    logic       w_l_gnt;
    logic       w_lock_win;
    logic       w_fetch_forced;

    assign w_lock_win     = l_lock && (r_wait_cnt < LP_MAX_WAIT);
    assign w_fetch_forced = (r_wait_cnt == LP_MAX_WAIT);

    // Grant selection: single requester wins, otherwise lock / starvation / round-robin
    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (rst) begin
            if (f_req && !l_req) begin
                w_f_gnt = 1'b1;
            end else if (l_req && !f_req) begin
                w_l_gnt = 1'b1;
            end else if (f_req && l_req) begin
                if (w_lock_win) begin
                    w_l_gnt = 1'b1;
                end else if (w_fetch_forced) begin
                    w_f_gnt = 1'b1;
                end else if (r_last_owner == OWN_LOADER) begin
                    w_f_gnt = 1'b1;
                end else begin
                    w_l_gnt = 1'b1;
                end
            end
        end
    end

    // Memory port drive from whichever requester holds the grant
    always_comb begin
        mem_A = '0;
        mem_W = 1'b0;
        mem_D = '0;
        if (w_f_gnt) begin
            mem_A = f_addr;
        end else if (w_l_gnt) begin
            mem_A = l_addr;
            mem_W = l_we;
            mem_D = l_wdata;
        end
    end

    // Arbitration history: last owner and fetch starvation counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_owner <= OWN_FETCH;
            r_wait_cnt   <= '0;
        end else begin
            if (w_f_gnt) begin
                r_last_owner <= OWN_FETCH;
            end else if (w_l_gnt) begin
                r_last_owner <= OWN_LOADER;
            end

            if (f_req && !w_f_gnt) begin
                if (r_wait_cnt < LP_MAX_WAIT) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Outstanding read tracking for the one-cycle-late response
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_pending <= 1'b0;
            r_rd_owner   <= OWN_FETCH;
        end else begin
            r_rd_pending <= w_f_gnt || (w_l_gnt && !l_we);
            r_rd_owner   <= w_l_gnt ? OWN_LOADER : OWN_FETCH;
        end
    end

    assign f_gnt = w_f_gnt;
    assign l_gnt = w_l_gnt;

    // A response landing while reset is held is dropped, not delivered
    assign f_rvalid = rst && r_rd_pending && (r_rd_owner == OWN_FETCH);
    assign l_rvalid = rst && r_rd_pending && (r_rd_owner == OWN_LOADER);

    assign f_rdata = mem_Q;
    assign l_rdata = mem_Q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and randomized checks of imem_arbiter against a
// behavioural reference model and a small synchronous memory model.
module tb_imem_arbiter;

    localparam int ADDR     = 16;
    localparam int WORD     = 32;
    localparam int MAX_WAIT = 8;

    logic            clk;
    logic            rst;
    logic            f_req;
    logic [ADDR-1:0] f_addr;
    logic            f_gnt;
    logic            f_rvalid;
    logic [WORD-1:0] f_rdata;
    logic            l_req;
    logic            l_we;
    logic [ADDR-1:0] l_addr;
    logic [WORD-1:0] l_wdata;
    logic            l_lock;
    logic            l_gnt;
    logic            l_rvalid;
    logic [WORD-1:0] l_rdata;
    logic [ADDR-1:0] mem_A;
    logic            mem_W;
    logic [WORD-1:0] mem_D;
    logic [WORD-1:0] mem_Q;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // memory seen by the DUT, and the bench's own shadow copy for expectations
    logic [WORD-1:0] tb_mem  [256];
    logic [WORD-1:0] ref_mem [256];

    // reference model state
    bit              m_last_loader;
    int              m_wait;
    bit              m_frv;
    bit              m_lrv;
    logic [WORD-1:0] m_data;
    bit              e_fg;
    bit              e_lg;
    bit              last_fg;
    bit              last_lg;

    imem_arbiter #(
        .ADDR     (ADDR),
        .WORD     (WORD),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_lock   (l_lock),
        .l_gnt    (l_gnt),
        .l_rvalid (l_rvalid),
        .l_rdata  (l_rdata),
        .mem_A    (mem_A),
        .mem_W    (mem_W),
        .mem_D    (mem_D),
        .mem_Q    (mem_Q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // synchronous single-port memory, registered read data
    always @(posedge clk) begin
        if (mem_W) tb_mem[mem_A[7:0]] <= mem_D;
        mem_Q <= tb_mem[mem_A[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock cycle: predict, compare, advance the model
    task automatic step();
        logic [ADDR-1:0] e_addr;
        e_fg = 1'b0;
        e_lg = 1'b0;
        if (rst) begin
            if (f_req && !l_req)                     e_fg = 1'b1;
            else if (l_req && !f_req)                e_lg = 1'b1;
            else if (f_req && l_req) begin
                if (l_lock && m_wait < MAX_WAIT)     e_lg = 1'b1;
                else if (m_wait == MAX_WAIT)         e_fg = 1'b1;
                else if (m_last_loader)              e_fg = 1'b1;
                else                                 e_lg = 1'b1;
            end
        end
        e_addr = e_fg ? f_addr : (e_lg ? l_addr : '0);
        #1;
        check("f_gnt", 32'(f_gnt), 32'(e_fg));
        check("l_gnt", 32'(l_gnt), 32'(e_lg));
        check("mem_W", 32'(mem_W), 32'(e_lg && l_we));
        check("mem_A", 32'(mem_A), 32'(e_addr));
        if (!e_fg) check("mem_D", mem_D, e_lg ? l_wdata : '0);
        check("f_rvalid", 32'(f_rvalid), 32'(m_frv && rst));
        check("l_rvalid", 32'(l_rvalid), 32'(m_lrv && rst));
        if (m_frv && rst) check("f_rdata", f_rdata, m_data);
        if (m_lrv && rst) check("l_rdata", l_rdata, m_data);
        @(posedge clk);
        last_fg = e_fg;
        last_lg = e_lg;
        if (!rst) begin
            m_last_loader = 1'b0;
            m_wait        = 0;
            m_frv         = 1'b0;
            m_lrv         = 1'b0;
        end else begin
            if (e_fg) m_last_loader = 1'b0;
            if (e_lg) m_last_loader = 1'b1;
            if (f_req && !e_fg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else                m_wait = 0;
            m_frv = e_fg;
            m_lrv = e_lg && !l_we;
            if (e_fg || (e_lg && !l_we)) m_data = ref_mem[e_addr[7:0]];
            if (e_lg && l_we) ref_mem[l_addr[7:0]] = l_wdata;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 32'h0101_0101 * i ^ 32'hA5A5_0000;
            ref_mem[i] = 32'h0101_0101 * i ^ 32'hA5A5_0000;
        end
        tb_mem[4]  = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        m_last_loader = 1'b0;
        m_wait = 0;
        m_frv  = 1'b0;
        m_lrv  = 1'b0;
        m_data = '0;
        last_fg = 1'b0;
        last_lg = 1'b0;

        // reset held with both requesters active
        rst = 1'b0; f_req = 1'b1; f_addr = 16'h0001;
        l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0002; l_wdata = '0; l_lock = 1'b0;
        @(posedge clk);
        @(negedge clk);
        repeat (3) step();

        // release: loader first, then alternation
        rst = 1'b1;
        repeat (6) step();

        // fetch alone reads 0x0004
        l_req = 1'b0; f_req = 1'b1; f_addr = 16'h0004;
        step();
        f_req = 1'b0;
        step();

        // loader write to 0x0010, then fetch reads it back
        l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0010; l_wdata = 32'h1234_5678;
        step();
        l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 16'h0010;
        step();
        f_req = 1'b0;
        step();

        // locked loader burst against a continuously requesting fetch
        f_req = 1'b1; f_addr = 16'h0030;
        l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0031; l_lock = 1'b1;
        repeat (20) step();

        // alternating loader 0x0020 / fetch 0x0021 reads
        f_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
        step();
        f_req = 1'b1; f_addr = 16'h0021;
        l_req = 1'b1; l_addr = 16'h0020;
        repeat (8) step();

        // reset in the cycle after a granted fetch read
        l_req = 1'b0; f_req = 1'b1; f_addr = 16'h0004;
        step();
        rst = 1'b0; f_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        f_req = 1'b1; f_addr = 16'h0005;
        step();
        f_req = 1'b0;
        step();

        // randomized traffic honouring the hold-until-granted rule
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) != 0);
            if (!(f_req && !last_fg)) begin
                f_req  = ($urandom_range(0, 3) != 0);
                f_addr = 16'($urandom_range(0, 255));
            end
            if (!(l_req && !last_lg)) begin
                l_req   = ($urandom_range(0, 2) != 0);
                l_we    = ($urandom_range(0, 1) != 0);
                l_addr  = 16'($urandom_range(0, 255));
                l_wdata = $urandom;
                l_lock  = ($urandom_range(0, 3) == 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
